mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk_i (all state on rising edge) and rstn_i (synchronous, active low).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the number of bus cycles without ack/err before a forced error.
REQ-003 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk_i  in  1  clock
- rstn_i  in  1  sync active-low reset
- iport_req_i  in  1  fetch request, held until iport_ack_o/iport_err_o
- iport_addr_i  in  32  fetch address
- iport_data_o  out  32  fetched word
- iport_ack_o / iport_err_o  out  1  one-cycle completion / error pulse
- dport_req_i  in  1  load/store request, held until completion
- dport_addr_i  in  32  data address
- dport_wdata_i  in  32  store data
- dport_sel_i  in  4  byte lanes
- dport_we_i  in  1  1 = store
- dport_data_o  out  32  load data
- dport_ack_o / dport_err_o  out  1  one-cycle completion / error pulse
- mem_cyc_o, mem_stb_o  out  1  bus cycle/strobe
- mem_addr_o  out  32
- mem_wdata_o  out  32
- mem_sel_o  out  4
- mem_we_o  out  1
- mem_data_i  in  32
- mem_ack_i, mem_err_i  in  1

Function
REQ-004 The FSM SHALL have states IDLE, BUS, RESP; all outputs SHALL be registered.
REQ-005 IDLE SHALL sample requests:
- none -> stay in IDLE;
- only one -> grant it;
- both -> grant the port not granted last (last_grant resets to I, so the first tie goes to D).
REQ-006 On grant, the block SHALL latch the granted port's addr/wdata/sel/we onto the mem_* outputs and assert mem_cyc_o = mem_stb_o = 1 in the next cycle (BUS).
REQ-007 For I grants, the block SHALL drive mem_we_o = 0 and mem_sel_o = 4'hF.
REQ-008 In BUS, the mem_* outputs SHALL stay stable until mem_ack_i or mem_err_i is sampled.
REQ-009 On the ack/err edge, the block SHALL:
- deassert mem_cyc_o/mem_stb_o;
- latch mem_data_i into the granted port's data_o;
- enter RESP.
REQ-010 In RESP, exactly one of the granted port's ack_o/err_o SHALL be high for one cycle; data_o SHALL hold its value until the next completion on that port. RESP always returns to IDLE.
REQ-011 If mem_ack_i and mem_err_i are sampled together, err SHALL win.
REQ-012 A timeout counter SHALL clear on entering BUS and increment each BUS cycle. On reaching TIMEOUT_CYCLES without ack/err, the block SHALL end the bus cycle and pulse err on the granted port.
REQ-013 Minimum latency SHALL be: req sampled at edge k, BUS at k+1, ack sampled at k+1 -> RESP at k+2. The earliest next grant is sampled at edge k+3.
REQ-014 A requester deasserting req mid-BUS SHALL NOT abort the transaction; the completion pulse still issues.
REQ-015 Non-granted ports SHALL see ack_o = err_o = 0; their requests SHALL wait with no loss.
REQ-016 last_grant SHALL update on every grant.

Reset
REQ-017 On rstn_i = 0 at a clock edge:
- state = IDLE, last_grant = I, timeout = 0;
- all mem_* outputs = 0 and all ack/err = 0;
- iport_data_o = dport_data_o = 0.
REQ-018 Reset during BUS SHALL drop mem_cyc_o/mem_stb_o on that edge and issue no completion pulse; a late mem_ack_i after reset SHALL be ignored.

Structure
REQ-019 The state enum (IDLE/BUS/RESP), the grant enum (GNT_I/GNT_D) and the default TIMEOUT_CYCLES SHALL live in the shared core package.
REQ-020 The tie-break logic SHALL be one sub-module, mem_arb_pick (inputs: two reqs, last_grant; output: grant, valid); everything else stays in mem_arbiter.

Verification
REQ-021 Single fetch: iport_req_i = 1, addr 0x100, memory acks the first BUS cycle with 0xDEADBEEF -> mem_cyc_o high for 1 cycle; iport_ack_o pulses 2 cycles after req sampled with iport_data_o = 0xDEADBEEF.
REQ-022 Simultaneous requests after reset: both req held -> D granted first (store addr 0x200, wdata 0x12345678, sel 0x3, mem_we_o = 1), then I. A third tie SHALL grant D.
REQ-023 Error priority: mem_ack_i and mem_err_i both high in the same cycle on a D load -> dport_err_o = 1, dport_ack_o = 0.
REQ-024 Timeout: TIMEOUT_CYCLES = 4, memory never responds -> mem_cyc_o falls after 4 BUS cycles; iport_err_o pulses once; FSM returns to IDLE.
REQ-025 Reset mid-BUS: rstn_i = 0 on the second BUS cycle, then mem_ack_i the following cycle -> mem_cyc_o = 0 at the reset edge; no ack/err pulse; FSM in IDLE.
REQ-026 Req drop: dport_req_i falls during BUS -> transaction completes and dport_ack_o still pulses; no second transaction starts.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and defaults for the fetch/data memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  typedef enum logic {GNT_I, GNT_D} gnt_e;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request ports and memory bus of the arbiter
interface mem_arbiter_if;
  logic        iport_req_i;
  logic [31:0] iport_addr_i;
  logic [31:0] iport_data_o;
  logic        iport_ack_o;
  logic        iport_err_o;
  logic        dport_req_i;
  logic [31:0] dport_addr_i;
  logic [31:0] dport_wdata_i;
  logic [3:0]  dport_sel_i;
  logic        dport_we_i;
  logic [31:0] dport_data_o;
  logic        dport_ack_o;
  logic        dport_err_o;
  logic        mem_cyc_o;
  logic        mem_stb_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_sel_o;
  logic        mem_we_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic        mem_err_i;
  modport slave (
    input  iport_req_i, iport_addr_i,
    output iport_data_o, iport_ack_o, iport_err_o,
    input  dport_req_i, dport_addr_i, dport_wdata_i, dport_sel_i, dport_we_i,
    output dport_data_o, dport_ack_o, dport_err_o,
    output mem_cyc_o, mem_stb_o, mem_addr_o, mem_wdata_o, mem_sel_o, mem_we_o,
    input  mem_data_i, mem_ack_i, mem_err_i
  );
  modport master (
    output iport_req_i, iport_addr_i,
    input  iport_data_o, iport_ack_o, iport_err_o,
    output dport_req_i, dport_addr_i, dport_wdata_i, dport_sel_i, dport_we_i,
    input  dport_data_o, dport_ack_o, dport_err_o,
    input  mem_cyc_o, mem_stb_o, mem_addr_o, mem_wdata_o, mem_sel_o, mem_we_o,
    output mem_data_i, mem_ack_i, mem_err_i
  );
endinterface

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: grant selection, alternating on ties against the last grant
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic ireq_i,
  input  logic dreq_i,
  input  gnt_e last_i,
  output gnt_e gnt_o,
  output logic valid_o
);
  assign valid_o = ireq_i | dreq_i;
  assign gnt_o = gnt_e'(dreq_i & (~ireq_i | (last_i == GNT_I)));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data ports onto one registered memory bus
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic clk_i,
  input logic rstn_i,
  mem_arbiter_if.slave bus
);
  state_e state_q, state_d;
  gnt_e gnt_q, gnt_d, last_q, last_d, pick_gnt;
  logic [31:0] to_q, to_d, addr_q, addr_d, wdata_q, wdata_d, idata_q, idata_d, ddata_q, ddata_d;
  logic [3:0] sel_q, sel_d;
  logic cyc_q, cyc_d, we_q, we_d;
  logic iack_q, iack_d, ierr_q, ierr_d, dack_q, dack_d, derr_q, derr_d;
  logic pick_vld, pick_d, resp, fail, done;
  mem_arb_pick u_pick (
    .ireq_i (bus.iport_req_i),
    .dreq_i (bus.dport_req_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .valid_o(pick_vld)
  );
  assign pick_d = pick_gnt == GNT_D;
  assign resp = bus.mem_ack_i | bus.mem_err_i;
  // a bus error or an expired timeout both end the cycle as an error
  assign fail = bus.mem_err_i | (to_q == TIMEOUT_CYCLES - 1);
  assign done = resp | fail;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    to_d = to_q;
    cyc_d = cyc_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    sel_d = sel_q;
    we_d = we_q;
    idata_d = idata_q;
    ddata_d = ddata_q;
    iack_d = 1'b0;
    ierr_d = 1'b0;
    dack_d = 1'b0;
    derr_d = 1'b0;
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d = BUS;
        gnt_d = pick_gnt;
        last_d = pick_gnt;
        to_d = '0;
        cyc_d = 1'b1;
        addr_d = pick_d ? bus.dport_addr_i : bus.iport_addr_i;
        wdata_d = pick_d ? bus.dport_wdata_i : '0;
        sel_d = pick_d ? bus.dport_sel_i : 4'hF;
        we_d = pick_d & bus.dport_we_i;
      end
      BUS: if (done) begin
        state_d = RESP;
        cyc_d = 1'b0;
        idata_d = (resp && gnt_q == GNT_I) ? bus.mem_data_i : idata_q;
        ddata_d = (resp && gnt_q == GNT_D) ? bus.mem_data_i : ddata_q;
        iack_d = gnt_q == GNT_I && !fail;
        ierr_d = gnt_q == GNT_I && fail;
        dack_d = gnt_q == GNT_D && !fail;
        derr_d = gnt_q == GNT_D && fail;
      end else begin
        to_d = to_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      gnt_q <= GNT_I;
      last_q <= GNT_I;
      to_q <= '0;
      cyc_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      idata_q <= '0;
      ddata_q <= '0;
      iack_q <= 1'b0;
      ierr_q <= 1'b0;
      dack_q <= 1'b0;
      derr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      to_q <= to_d;
      cyc_q <= cyc_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      sel_q <= sel_d;
      we_q <= we_d;
      idata_q <= idata_d;
      ddata_q <= ddata_d;
      iack_q <= iack_d;
      ierr_q <= ierr_d;
      dack_q <= dack_d;
      derr_q <= derr_d;
    end
  end
  assign bus.mem_cyc_o = cyc_q;
  assign bus.mem_stb_o = cyc_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_sel_o = sel_q;
  assign bus.mem_we_o = we_q;
  assign bus.iport_data_o = idata_q;
  assign bus.iport_ack_o = iack_q;
  assign bus.iport_err_o = ierr_q;
  assign bus.dport_data_o = ddata_q;
  assign bus.dport_ack_o = dack_q;
  assign bus.dport_err_o = derr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus multi-cycle corner sequences
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  typedef struct {
    logic ireq, dreq;
    logic [31:0] iaddr, daddr, wdata;
    logic [3:0] sel;
    logic we;
    int wait_n;
    logic ack, err;
    logic [31:0] rdata;
    logic exp_d;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0] exp_sel;
    logic exp_we, exp_ack, exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vt[7];
  always #5 clk = ~clk;
  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic pulses_zero(input string name);
    chk(name, {28'd0, bus.iport_ack_o, bus.iport_err_o, bus.dport_ack_o, bus.dport_err_o}, 32'd0);
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    bus.iport_req_i = v.ireq;
    bus.iport_addr_i = v.iaddr;
    bus.dport_req_i = v.dreq;
    bus.dport_addr_i = v.daddr;
    bus.dport_wdata_i = v.wdata;
    bus.dport_sel_i = v.sel;
    bus.dport_we_i = v.we;
    bus.mem_ack_i = 1'b0;
    bus.mem_err_i = 1'b0;
    tick;
    chk($sformatf("v%0d_cyc", idx), {31'd0, bus.mem_cyc_o}, 32'd1);
    chk($sformatf("v%0d_stb", idx), {31'd0, bus.mem_stb_o}, 32'd1);
    chk($sformatf("v%0d_addr", idx), bus.mem_addr_o, v.exp_addr);
    chk($sformatf("v%0d_wdata", idx), bus.mem_wdata_o, v.exp_wdata);
    chk($sformatf("v%0d_sel", idx), {28'd0, bus.mem_sel_o}, {28'd0, v.exp_sel});
    chk($sformatf("v%0d_we", idx), {31'd0, bus.mem_we_o}, {31'd0, v.exp_we});
    pulses_zero($sformatf("v%0d_bus_pulses", idx));
    for (int c = 0; c < v.wait_n; c++) begin
      tick;
      chk($sformatf("v%0d_hold_cyc", idx), {31'd0, bus.mem_cyc_o}, 32'd1);
      chk($sformatf("v%0d_hold_addr", idx), bus.mem_addr_o, v.exp_addr);
    end
    bus.mem_ack_i = v.ack;
    bus.mem_err_i = v.err;
    bus.mem_data_i = v.rdata;
    tick;
    bus.mem_ack_i = 1'b0;
    bus.mem_err_i = 1'b0;
    bus.iport_req_i = 1'b0;
    bus.dport_req_i = 1'b0;
    chk($sformatf("v%0d_end_cyc", idx), {31'd0, bus.mem_cyc_o}, 32'd0);
    chk($sformatf("v%0d_iack", idx), {31'd0, bus.iport_ack_o}, {31'd0, !v.exp_d && v.exp_ack});
    chk($sformatf("v%0d_ierr", idx), {31'd0, bus.iport_err_o}, {31'd0, !v.exp_d && v.exp_err});
    chk($sformatf("v%0d_dack", idx), {31'd0, bus.dport_ack_o}, {31'd0, v.exp_d && v.exp_ack});
    chk($sformatf("v%0d_derr", idx), {31'd0, bus.dport_err_o}, {31'd0, v.exp_d && v.exp_err});
    chk($sformatf("v%0d_data", idx), v.exp_d ? bus.dport_data_o : bus.iport_data_o, v.rdata);
    tick;
    pulses_zero($sformatf("v%0d_idle_pulses", idx));
  endtask
  initial begin
    int cyc_n, err_n, ack_n;
    bus.iport_req_i = 1'b0;
    bus.iport_addr_i = '0;
    bus.dport_req_i = 1'b0;
    bus.dport_addr_i = '0;
    bus.dport_wdata_i = '0;
    bus.dport_sel_i = '0;
    bus.dport_we_i = 1'b0;
    bus.mem_data_i = '0;
    bus.mem_ack_i = 1'b0;
    bus.mem_err_i = 1'b0;
    // ireq dreq iaddr daddr wdata sel we wait ack err rdata | exp_d addr wdata sel we ack err
    vt[0] = '{1'b1, 1'b0, 32'h100, '0, '0, 4'h0, 1'b0, 0, 1'b1, 1'b0, 32'hDEADBEEF,
              1'b0, 32'h100, '0, 4'hF, 1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b1, '0, 32'h300, 32'hAAAA5555, 4'h1, 1'b0, 1, 1'b1, 1'b0, 32'hCAFEF00D,
              1'b1, 32'h300, 32'hAAAA5555, 4'h1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'h104, 32'h304, 32'h99999999, 4'hF, 1'b1, 2, 1'b1, 1'b0, 32'h11111111,
              1'b0, 32'h104, '0, 4'hF, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1, 32'h108, 32'h204, 32'h87654321, 4'hC, 1'b1, 0, 1'b1, 1'b0, 32'h0,
              1'b1, 32'h204, 32'h87654321, 4'hC, 1'b1, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b1, '0, 32'h308, '0, 4'hF, 1'b0, 0, 1'b1, 1'b1, 32'h55AA55AA,
              1'b1, 32'h308, '0, 4'hF, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b0, 32'h10C, '0, '0, 4'h0, 1'b0, 1, 1'b0, 1'b1, 32'h77777777,
              1'b0, 32'h10C, '0, 4'hF, 1'b0, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 32'h110, 32'h30C, 32'h01020304, 4'h6, 1'b1, 0, 1'b1, 1'b0, 32'hFEEDFACE,
              1'b1, 32'h30C, 32'h01020304, 4'h6, 1'b1, 1'b1, 1'b0};
    tick;
    tick;
    chk("rst_cyc", {31'd0, bus.mem_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, bus.mem_stb_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'd0);
    chk("rst_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_sel_we", {27'd0, bus.mem_sel_o, bus.mem_we_o}, 32'd0);
    chk("rst_idata", bus.iport_data_o, 32'd0);
    chk("rst_ddata", bus.dport_data_o, 32'd0);
    pulses_zero("rst_pulses");
    rstn = 1'b1;
    tick;
    for (int i = 0; i < 7; i++) run_vec(vt[i], i);
    // reset on the second bus cycle, then a stale ack
    bus.dport_req_i = 1'b1;
    bus.dport_addr_i = 32'h500;
    bus.dport_we_i = 1'b0;
    tick;
    chk("mrst_bus1", {31'd0, bus.mem_cyc_o}, 32'd1);
    tick;
    chk("mrst_bus2", {31'd0, bus.mem_cyc_o}, 32'd1);
    rstn = 1'b0;
    tick;
    chk("mrst_cyc", {31'd0, bus.mem_cyc_o}, 32'd0);
    chk("mrst_stb", {31'd0, bus.mem_stb_o}, 32'd0);
    chk("mrst_ddata", bus.dport_data_o, 32'd0);
    chk("mrst_idata", bus.iport_data_o, 32'd0);
    rstn = 1'b1;
    bus.dport_req_i = 1'b0;
    bus.mem_ack_i = 1'b1;
    bus.mem_data_i = 32'hBADBAD00;
    tick;
    bus.mem_ack_i = 1'b0;
    pulses_zero("mrst_late_ack");
    chk("mrst_idle_cyc", {31'd0, bus.mem_cyc_o}, 32'd0);
    tick;
    pulses_zero("mrst_late_ack2");
    chk("mrst_ddata_kept", bus.dport_data_o, 32'd0);
    // held ties after reset: D, then the waiting I, then D again
    bus.iport_req_i = 1'b1;
    bus.iport_addr_i = 32'h400;
    bus.dport_req_i = 1'b1;
    bus.dport_addr_i = 32'h200;
    bus.dport_wdata_i = 32'h12345678;
    bus.dport_sel_i = 4'h3;
    bus.dport_we_i = 1'b1;
    tick;
    chk("tie1_cyc", {31'd0, bus.mem_cyc_o}, 32'd1);
    chk("tie1_addr", bus.mem_addr_o, 32'h200);
    chk("tie1_wdata", bus.mem_wdata_o, 32'h12345678);
    chk("tie1_sel", {28'd0, bus.mem_sel_o}, 32'h3);
    chk("tie1_we", {31'd0, bus.mem_we_o}, 32'd1);
    bus.mem_ack_i = 1'b1;
    bus.mem_data_i = 32'hA5A5A5A5;
    tick;
    bus.mem_ack_i = 1'b0;
    bus.dport_req_i = 1'b0;
    chk("tie1_dack", {31'd0, bus.dport_ack_o}, 32'd1);
    chk("tie1_iack", {31'd0, bus.iport_ack_o}, 32'd0);
    tick;
    chk("tie1_idle", {31'd0, bus.mem_cyc_o}, 32'd0);
    tick;
    chk("tie2_cyc", {31'd0, bus.mem_cyc_o}, 32'd1);
    chk("tie2_addr", bus.mem_addr_o, 32'h400);
    chk("tie2_we", {31'd0, bus.mem_we_o}, 32'd0);
    chk("tie2_sel", {28'd0, bus.mem_sel_o}, 32'hF);
    bus.mem_ack_i = 1'b1;
    bus.mem_data_i = 32'h5A5A5A5A;
    tick;
    bus.mem_ack_i = 1'b0;
    chk("tie2_iack", {31'd0, bus.iport_ack_o}, 32'd1);
    chk("tie2_dack", {31'd0, bus.dport_ack_o}, 32'd0);
    chk("tie2_idata", bus.iport_data_o, 32'h5A5A5A5A);
    chk("tie2_ddata_kept", bus.dport_data_o, 32'hA5A5A5A5);
    bus.dport_req_i = 1'b1;
    bus.dport_addr_i = 32'h208;
    bus.dport_we_i = 1'b0;
    tick;
    tick;
    chk("tie3_addr", bus.mem_addr_o, 32'h208);
    bus.mem_ack_i = 1'b1;
    tick;
    bus.mem_ack_i = 1'b0;
    bus.iport_req_i = 1'b0;
    bus.dport_req_i = 1'b0;
    chk("tie3_dack", {31'd0, bus.dport_ack_o}, 32'd1);
    tick;
    // timeout with a silent memory
    bus.iport_req_i = 1'b1;
    bus.iport_addr_i = 32'h600;
    cyc_n = 0;
    err_n = 0;
    ack_n = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      cyc_n += int'(bus.mem_cyc_o);
      ack_n += int'(bus.iport_ack_o);
      if (bus.iport_err_o) begin
        err_n++;
        bus.iport_req_i = 1'b0;
      end
    end
    chk("to_cycles", cyc_n, 32'd4);
    chk("to_err_pulses", err_n, 32'd1);
    chk("to_ack_pulses", ack_n, 32'd0);
    // requester drops req mid-bus
    bus.dport_req_i = 1'b1;
    bus.dport_addr_i = 32'h700;
    bus.dport_wdata_i = 32'h0000BEEF;
    bus.dport_sel_i = 4'hF;
    bus.dport_we_i = 1'b1;
    tick;
    chk("drop_cyc", {31'd0, bus.mem_cyc_o}, 32'd1);
    bus.dport_req_i = 1'b0;
    tick;
    chk("drop_hold_cyc", {31'd0, bus.mem_cyc_o}, 32'd1);
    chk("drop_hold_addr", bus.mem_addr_o, 32'h700);
    bus.mem_ack_i = 1'b1;
    tick;
    bus.mem_ack_i = 1'b0;
    chk("drop_dack", {31'd0, bus.dport_ack_o}, 32'd1);
    cyc_n = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      cyc_n += int'(bus.mem_cyc_o);
    end
    chk("drop_no_second", cyc_n, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
